quad_decoder: RTL and testbench
===============================

QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning width of the position counter.
REQ-002 SHALL have parameter FILT_LEN, default 4, meaning the number of consecutive identical synchronized samples required to accept an input level (range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low; this polarity and synchronicity are fixed.
REQ-005 SHALL have port enc_a  input  1  quadrature phase A, asynchronous to clk.
REQ-006 SHALL have port enc_b  input  1  quadrature phase B, asynchronous to clk.
REQ-007 SHALL have port enc_z  input  1  index pulse, asynchronous; used only when QDEC_INDEX_EN is defined.
REQ-008 SHALL have port clr  input  1  synchronous position clear, active-high.
REQ-009 SHALL have port pos_cnt  output  WIDTH  signed two's-complement position.
REQ-010 SHALL have port dir  output  1  direction of the last valid step; 1 = forward.
REQ-011 SHALL have port step  output  1  one-cycle pulse for each valid count.
REQ-012 SHALL have port err  output  1  one-cycle pulse for an illegal transition.

Function
REQ-013 SHALL pass enc_a, enc_b and enc_z through a 2-flop synchronizer each.
REQ-014 SHALL change a filtered level only after its synchronized input differs from it for FILT_LEN consecutive cycles; each channel SHALL restart its stability counter when the input toggles.
REQ-015 SHALL decode 4x: each accepted change of filtered {A,B} SHALL produce exactly one count.
REQ-016 SHALL treat the sequence {A,B} 00->10->11->01->00 (A leads B) as forward (+1, dir=1) and the reverse sequence as backward (-1, dir=0).
REQ-017 SHALL, when A and B are accepted in the same cycle (both bits change), leave pos_cnt and dir unchanged, pulse err for one cycle and not pulse step.
REQ-018 SHALL pulse step in the same cycle that pos_cnt is updated.
REQ-019 SHALL make pos_cnt wrap modulo 2^WIDTH: max positive +1 -> most negative; 0 -1 -> all ones.
REQ-020 SHALL apply clr with highest priority: in a cycle with clr=1, pos_cnt SHALL become 0 at the next edge, any coincident step SHALL be discarded, and step and err SHALL be 0.
REQ-021 SHALL register pos_cnt exactly FILT_LEN+3 clk cycles after a clean edge on enc_a or enc_b is first sampled.

Reset
REQ-022 SHALL on rst_n=0 asynchronously set pos_cnt=0, dir=0, step=0 and err=0, clear the synchronizers and filter counters to 0, and set the filtered levels to 0.
REQ-023 SHALL, when reset is released with enc_a/enc_b high, accept the levels after the filter delay and treat the first transition from the reset state {0,0} by the normal rules (single-bit change -> count; dual-bit change -> err).

Configuration
REQ-024 SHALL, with macro QDEC_INDEX_EN defined, clear pos_cnt to 0 on the rising edge of filtered Z, with priority clr > index > step, and SHALL suppress the step pulse in that cycle.
REQ-025 SHALL, without QDEC_INDEX_EN, ignore enc_z and omit its synchronizer, filter and index logic.

Structure
REQ-026 SHALL place the forward-transition encoding constants and the FILT_LEN limits in a shared package/include file qdec_defs.
REQ-027 SHALL implement the synchronizer and filter in one sub-module, qdec_filter, instantiated once per channel.

Verification
REQ-028 SHALL cover forward: 8 clean forward cycles (32 edges), FILT_LEN=4 -> pos_cnt=32, dir=1, 32 step pulses, err never high.
REQ-029 SHALL cover reverse and wrap: start at 0, 3 backward edges -> pos_cnt=32'hFFFF_FFFD, dir=0.
REQ-030 SHALL cover glitch rejection: a 3-cycle pulse on enc_a with FILT_LEN=4 -> no step and pos_cnt unchanged; a 4-cycle pulse -> accepted.
REQ-031 SHALL cover illegal transitions: enc_a and enc_b toggled on the same clock from 00 to 11 -> one err pulse, pos_cnt unchanged.
REQ-032 SHALL cover clr priority: clr asserted in the cycle that a forward step lands with pos_cnt=10 -> pos_cnt=0 and no step pulse.
REQ-033 SHALL cover index (QDEC_INDEX_EN) and reset: a Z pulse at pos_cnt=57 -> pos_cnt=0; rst_n low mid-sequence -> all outputs 0 immediately.

Source files
------------

// File: rtl/qdec_defs.sv
// Shared constants for the quadrature decoder: forward Gray sequence and filter length limits.
package qdec_defs;

    localparam int FILT_LEN_MIN = 1;
    localparam int FILT_LEN_MAX = 15;
    localparam int FILT_CNT_W   = 4;

    // Forward rotation visits {A,B} = 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
    localparam logic [1:0] QDEC_S0 = 2'b00;
    localparam logic [1:0] QDEC_S1 = 2'b10;
    localparam logic [1:0] QDEC_S2 = 2'b11;
    localparam logic [1:0] QDEC_S3 = 2'b01;

    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            QDEC_S0: fwd_next = QDEC_S1;
            QDEC_S1: fwd_next = QDEC_S2;
            QDEC_S2: fwd_next = QDEC_S3;
            default: fwd_next = QDEC_S0;
        endcase
    endfunction

endpackage

// File: rtl/qdec_filter.sv
// Two-flop synchronizer plus stability filter for one encoder channel.
// Latency: 2 sync cycles + FILT_LEN stable cycles before o_lvl follows the pin.
// Backpressure: none; free-running on every clk edge.
module qdec_filter
    import qdec_defs::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_lvl
);

    localparam int LEN_C = (FILT_LEN < FILT_LEN_MIN) ? FILT_LEN_MIN :
                           (FILT_LEN > FILT_LEN_MAX) ? FILT_LEN_MAX : FILT_LEN;
    localparam logic [FILT_CNT_W-1:0] LAST = FILT_CNT_W'(LEN_C - 1);

    logic [1:0]            r_sync;
    logic [FILT_CNT_W-1:0] r_cnt;
    logic                  r_lvl;

    // Any sample matching the current level restarts the count from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
            r_cnt  <= '0;
            r_lvl  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] != r_lvl) begin
                if (r_cnt == LAST) begin
                    r_lvl <= r_sync[1];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + FILT_CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_lvl = r_lvl;

endmodule

// File: rtl/quad_decoder.sv
// 4x quadrature decoder with filtered inputs; index clear under `QDEC_INDEX_EN.
// Latency: pos_cnt/step update FILT_LEN+3 cycles after a pin edge is first sampled.
// Backpressure: none; step/err are single-cycle pulses, clr overrides everything.
module quad_decoder
    import qdec_defs::*;
#(
    parameter int WIDTH    = 32,
    parameter int FILT_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    enc_z,
    input  logic                    clr,
    output logic signed [WIDTH-1:0] pos_cnt,
    output logic                    dir,
    output logic                    step,
    output logic                    err
);

    logic             w_a;
    logic             w_b;
    logic             w_idx;
    logic             w_chg;
    logic             w_dual;
    logic             w_fwd;
    logic [1:0]       r_ab_cur;
    logic [1:0]       r_ab_prev;
    logic [WIDTH-1:0] r_pos;
    logic             r_dir;
    logic             r_step;
    logic             r_err;

    qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (.clk(clk), .rst_n(rst_n), .i_raw(enc_a), .o_lvl(w_a));
    qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (.clk(clk), .rst_n(rst_n), .i_raw(enc_b), .o_lvl(w_b));

`ifdef QDEC_INDEX_EN
    logic w_z;
    logic r_z_cur;
    logic r_z_prev;

    qdec_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (.clk(clk), .rst_n(rst_n), .i_raw(enc_z), .o_lvl(w_z));

    // Z rides the same two-stage pipeline as {A,B} so an index lines up with its step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_cur  <= 1'b0;
            r_z_prev <= 1'b0;
        end else begin
            r_z_cur  <= w_z;
            r_z_prev <= r_z_cur;
        end
    end

    assign w_idx = r_z_cur & ~r_z_prev;
`else
    logic w_unused_z;
    assign w_unused_z = enc_z;
    assign w_idx      = 1'b0;
`endif

    assign w_chg  = |(r_ab_cur ^ r_ab_prev);
    assign w_dual = &(r_ab_cur ^ r_ab_prev);
    assign w_fwd  = (r_ab_cur == fwd_next(r_ab_prev));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ab_cur  <= 2'b00;
            r_ab_prev <= 2'b00;
            r_pos     <= '0;
            r_dir     <= 1'b0;
            r_step    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ab_cur  <= {w_a, w_b};
            r_ab_prev <= r_ab_cur;
            r_step    <= 1'b0;
            r_err     <= 1'b0;
            if (clr) begin
                r_pos <= '0;
            end else if (w_idx) begin
                r_pos <= '0;
                r_err <= w_dual;
            end else if (w_dual) begin
                r_err <= 1'b1;
            end else if (w_chg) begin
                r_step <= 1'b1;
                r_dir  <= w_fwd;
                r_pos  <= w_fwd ? r_pos + WIDTH'(1) : r_pos - WIDTH'(1);
            end
        end
    end

    assign pos_cnt = r_pos;
    assign dir     = r_dir;
    assign step    = r_step;
    assign err     = r_err;

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized bench for quad_decoder against a window-based behavioural model, plus directed checks.
module tb_quad_decoder;

    localparam int W    = 32;
    localparam int F    = 4;
    localparam int HOLD = F + 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enc_a;
    logic         enc_b;
    logic         enc_z;
    logic         clr;
    logic [W-1:0] pos_cnt;
    logic         dir;
    logic         step;
    logic         err;

    quad_decoder #(.WIDTH(W), .FILT_LEN(F)) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .clr(clr), .pos_cnt(pos_cnt), .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int step_cnt = 0;
    int err_cnt  = 0;
    int last_step_cyc = -1;

    logic [1:0] SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int ph = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a filtered level flips once the last F synchronized samples all disagree
    // with it; an accepted change of the pair shows on the outputs two cycles later.
    bit         qa[$];
    bit         qb[$];
    bit         qz[$];
    logic [1:0] fh[$];
    bit         fzh[$];
    bit         fa, fb, fz;
    logic [W-1:0] m_pos;
    bit         m_dir, m_step, m_err;

    function automatic int gidx(input logic [1:0] s);
        case (s)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic bit accept(input bit q[$], input bit lvl);
        for (int k = 2; k <= F + 1; k++)
            if (q[q.size() - 1 - k] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        qa.delete(); qb.delete(); qz.delete(); fh.delete(); fzh.delete();
        repeat (F + 2) begin qa.push_back(1'b0); qb.push_back(1'b0); qz.push_back(1'b0); end
        repeat (4) begin fh.push_back(2'b00); fzh.push_back(1'b0); end
        fa = 0; fb = 0; fz = 0;
        m_pos = '0; m_dir = 0; m_step = 0; m_err = 0;
    endtask

    task automatic model_edge();
        logic [1:0] cur, prev, d;
        bit zrise, fwdm;
        qa.push_back(enc_a); void'(qa.pop_front());
        qb.push_back(enc_b); void'(qb.pop_front());
        qz.push_back(enc_z); void'(qz.pop_front());
        if (accept(qa, fa)) fa = !fa;
        if (accept(qb, fb)) fb = !fb;
        if (accept(qz, fz)) fz = !fz;
        fh.push_back({fa, fb});  void'(fh.pop_front());
        fzh.push_back(fz);       void'(fzh.pop_front());
        prev = fh[0];
        cur  = fh[1];
        d    = cur ^ prev;
`ifdef QDEC_INDEX_EN
        zrise = fzh[1] && !fzh[0];
`else
        zrise = 1'b0;
`endif
        m_step = 0;
        m_err  = 0;
        if (clr) begin
            m_pos = '0;
        end else if (zrise) begin
            m_pos = '0;
            m_err = (d == 2'b11);
        end else if (d == 2'b11) begin
            m_err = 1;
        end else if (d != 2'b00) begin
            fwdm   = (((gidx(cur) - gidx(prev) + 4) % 4) == 1);
            m_pos  = fwdm ? m_pos + W'(1) : m_pos - W'(1);
            m_dir  = fwdm;
            m_step = 1;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        total++;
        if ({pos_cnt, dir, step, err} !== {m_pos, m_dir, m_step, m_err}) begin
            bad++;
            $display("FAIL cycle %0d outputs: got pos=%0h dir=%0b step=%0b err=%0b expected pos=%0h dir=%0b step=%0b err=%0b",
                     cyc, pos_cnt, dir, step, err, m_pos, m_dir, m_step, m_err);
        end
        if (step === 1'b1) begin step_cnt++; last_step_cyc = cyc; end
        if (err === 1'b1) err_cnt++;
    end

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ph(input int p, input int n);
        ph    = p;
        enc_a = SEQ[p][1];
        enc_b = SEQ[p][0];
        hold(n);
    endtask

    task automatic step1(input bit f, input int n);
        set_ph(f ? (ph + 1) % 4 : (ph + 3) % 4, n);
    endtask

    task automatic pulse_clr();
        clr = 1'b1; hold(1); clr = 1'b0; hold(2);
    endtask

    task automatic clear_counts();
        step_cnt = 0; err_cnt = 0;
    endtask

    initial begin
        int c0;
        logic [W-1:0] p0;
        rst_n = 1'b0; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0; clr = 1'b0;
        @(negedge clk);
        hold(2);
        chk("reset_state", {pos_cnt, dir, step, err}, 64'd0);
        rst_n = 1'b1;
        hold(HOLD);

        clear_counts();
        repeat (32) step1(1'b1, HOLD);
        chk("fwd_pos", pos_cnt, 64'd32);
        chk("fwd_dir", dir, 64'd1);
        chk("fwd_steps", step_cnt, 64'd32);
        chk("fwd_err", err_cnt, 64'd0);

        pulse_clr();
        chk("clr_pos", pos_cnt, 64'd0);
        clear_counts();
        c0 = cyc;
        step1(1'b0, HOLD);
        chk("latency", 64'(last_step_cyc - c0), 64'(F + 4));
        repeat (2) step1(1'b0, HOLD);
        chk("rev_pos", pos_cnt, 64'hFFFF_FFFD);
        chk("rev_dir", dir, 64'd0);
        chk("rev_steps", step_cnt, 64'd3);

        p0 = pos_cnt;
        clear_counts();
        enc_a = !enc_a; hold(3); enc_a = !enc_a; hold(HOLD + 2);
        chk("glitch3_steps", step_cnt, 64'd0);
        chk("glitch3_pos", pos_cnt, 64'(p0));
        clear_counts();
        enc_a = !enc_a; hold(4); enc_a = !enc_a; hold(HOLD + 4);
        chk("glitch4_steps", step_cnt, 64'd2);
        chk("glitch4_err", err_cnt, 64'd0);

        set_ph(0, HOLD);
        p0 = pos_cnt;
        clear_counts();
        enc_a = 1'b1; enc_b = 1'b1; ph = 2;
        hold(HOLD + 2);
        chk("illegal_err", err_cnt, 64'd1);
        chk("illegal_steps", step_cnt, 64'd0);
        chk("illegal_pos", pos_cnt, 64'(p0));

        pulse_clr();
        repeat (10) step1(1'b1, HOLD);
        chk("pre_clr_pos", pos_cnt, 64'd10);
        clear_counts();
        ph = (ph + 1) % 4; enc_a = SEQ[ph][1]; enc_b = SEQ[ph][0];
        hold(F + 3);
        clr = 1'b1; hold(1); clr = 1'b0; hold(4);
        chk("clr_prio_steps", step_cnt, 64'd0);
        chk("clr_prio_pos", pos_cnt, 64'd0);
        step1(1'b1, HOLD);
        chk("post_clr_pos", pos_cnt, 64'd1);

`ifdef QDEC_INDEX_EN
        pulse_clr();
        repeat (57) step1(1'b1, HOLD);
        chk("pre_index_pos", pos_cnt, 64'd57);
        enc_z = 1'b1; hold(HOLD); enc_z = 1'b0; hold(HOLD);
        chk("index_pos", pos_cnt, 64'd0);
`endif

        for (int i = 0; i < 500; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) begin
                step1(1'($urandom_range(0, 1)), int'($urandom_range(1, F + 5)));
            end else if (r == 6) begin
                enc_a = !enc_a; enc_b = !enc_b; ph = (ph + 2) % 4;
                hold(int'($urandom_range(1, F + 5)));
            end else if (r == 7) begin
                clr = 1'b1; hold(1); clr = 1'b0;
            end else begin
                enc_z = !enc_z;
                hold(int'($urandom_range(1, F + 5)));
            end
        end

        enc_z = 1'b0;
        hold(HOLD);
        repeat (3) step1(1'b1, HOLD);
        ph = (ph + 1) % 4; enc_a = SEQ[ph][1]; enc_b = SEQ[ph][0];
        hold(3);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {pos_cnt, dir, step, err}, 64'd0);
        @(negedge clk);
        enc_a = 1'b1; enc_b = 1'b1; ph = 2;
        hold(3);
        rst_n = 1'b1;
        clear_counts();
        hold(HOLD + 4);
        chk("reset_high_err", err_cnt, 64'd1);
        chk("reset_high_pos", pos_cnt, 64'd0);
        chk("reset_high_steps", step_cnt, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
